// File: rtl/prbs_pkg.sv
// Shared types and helpers for the PRBS checker slice.
// Holds the checker FSM encoding, default tap masks and the LFSR feedback function.
package prbs_pkg;

    typedef enum logic {
        CHK_SEARCH = 1'b0,
        CHK_LOCKED = 1'b1
    } chk_state_e;

    localparam logic [6:0] PRBS7_TAPS = 7'h60;
    localparam logic [7:0] PRBS8_TAPS = 8'hB8;

    // Widest LFSR the feedback helper supports.
    localparam int FB_MAX_W = 64;

    // Parity of the tapped state bits.
    function automatic logic prbs_fb(
        input logic [FB_MAX_W-1:0] st,
        input logic [FB_MAX_W-1:0] taps
    );
        return ^(st & taps);
    endfunction

endpackage

// File: rtl/prbs_err_window.sv
// Error-density window for the PRBS checker: counts valid bits and errors per block.
// Ports: clk, rst (async low), enable (valid bit while locked), err, restart -> lose_lock.
module prbs_err_window
    import prbs_pkg::*;
#(
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic err,
    input  logic restart,
    output logic lose_lock
);

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int ERR_W = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH + 1) : 1;

    logic [WIN_W-1:0] win_q;
    logic [ERR_W-1:0] werr_q;
    logic             win_end;

    assign win_end = (win_q == WIN_W'(WINDOW - 1));

    // The current bit's own error counts toward the threshold.
    assign lose_lock = enable && err &&
                       (werr_q == ERR_W'(LOSS_THRESH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q  <= '0;
            werr_q <= '0;
        end else if (restart) begin
            win_q  <= '0;
            werr_q <= '0;
        end else if (enable) begin
            if (win_end || lose_lock) begin
                win_q  <= '0;
                werr_q <= '0;
            end else begin
                win_q <= win_q + WIN_W'(1);
                if (err) begin
                    werr_q <= werr_q + ERR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-seeds a Fibonacci LFSR, locks, then counts bit errors.
// Ports: clk, rst (async low), in_valid, in_bit, clear_cnt -> locked, err_pulse, err_count, state.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned           LENGTH      = 8,
    parameter logic [LENGTH-1:0]     TAPS        = PRBS8_TAPS,
    parameter int                    LOCK_COUNT  = 16,
    parameter int                    WINDOW      = 64,
    parameter int                    LOSS_THRESH = 4,
    parameter int                    ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_bit,
    input  logic                 clear_cnt,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [LENGTH-1:0]    state
);

    localparam int FILL_W  = $clog2(LENGTH + 1);
    localparam int MATCH_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;

    chk_state_e cur;
    chk_state_e nxt;

    logic [LENGTH-1:0]    state_q;
    logic [FILL_W-1:0]    fill_q;
    logic [MATCH_W-1:0]   match_q;
    logic                 err_pulse_q;
    logic [ERR_CNT_W-1:0] err_count_q;

    logic fb;
    logic hit;
    logic filled;
    logic seed_ok;
    logic lock_hit;
    logic err;
    logic lose_lock;
    logic shift_bit;
    logic is_locked;
    logic cnt_sat;

    assign fb = prbs_fb(FB_MAX_W'(state_q), FB_MAX_W'(TAPS));

    assign hit     = (in_bit == fb);
    assign filled  = (fill_q == FILL_W'(LENGTH));
    // An all-zero register predicts zeros forever; never trust it.
    assign seed_ok = hit && (state_q != '0);
    assign cnt_sat = &err_count_q;

    assign lock_hit = in_valid && (cur == CHK_SEARCH) && filled &&
                      seed_ok &&
                      (match_q == MATCH_W'(LOCK_COUNT - 1));

    assign err = in_valid && (cur == CHK_LOCKED) && !hit;

    prbs_err_window #(
        .WINDOW      (WINDOW),
        .LOSS_THRESH (LOSS_THRESH)
    ) u_win (
        .clk       (clk),
        .rst       (rst),
        .enable    (in_valid && (cur == CHK_LOCKED)),
        .err       (err),
        .restart   (cur == CHK_SEARCH),
        .lose_lock (lose_lock)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur <= CHK_SEARCH;
        end else begin
            cur <= nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        nxt = cur;
        unique case (cur)
            CHK_SEARCH: begin
                if (lock_hit) begin
                    nxt = CHK_LOCKED;
                end
            end
            CHK_LOCKED: begin
                if (lose_lock) begin
                    nxt = CHK_SEARCH;
                end
            end
        endcase
    end

    // Output decode: seed from the line while searching, free-run once locked.
    always_comb begin
        is_locked = 1'b0;
        shift_bit = in_bit;
        unique case (1'b1)
            (cur == CHK_LOCKED): begin
                is_locked = 1'b1;
                shift_bit = fb;
            end
            default: begin
                is_locked = 1'b0;
                shift_bit = in_bit;
            end
        endcase
    end

    // Local LFSR plus fill and match counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
            fill_q  <= '0;
            match_q <= '0;
        end else if (in_valid) begin
            state_q <= {state_q[LENGTH-2:0], shift_bit};
            if (cur == CHK_SEARCH) begin
                if (!filled) begin
                    fill_q <= fill_q + FILL_W'(1);
                end else if (seed_ok) begin
                    match_q <= match_q + MATCH_W'(1);
                end else begin
                    match_q <= '0;
                end
            end else if (lose_lock) begin
                fill_q  <= '0;
                match_q <= '0;
            end
        end
    end

    // Error pulse and saturating counter; a clear yields to a same-edge error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_pulse_q <= err;
            if (clear_cnt) begin
                err_count_q <= ERR_CNT_W'(err);
            end else if (err && !cnt_sat) begin
                err_count_q <= err_count_q + ERR_CNT_W'(1);
            end
        end
    end

    assign locked    = is_locked;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign state     = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker with a per-cycle scoreboard.
// A second instance with a 2-bit counter shares the stimulus for saturation.
module tb_prbs_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_bit;
    logic        clear_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [7:0]  state;
    logic        locked2;
    logic        err_pulse2;
    logic [1:0]  err_count2;
    logic [7:0]  state2;

    prbs_checker dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clear_cnt (clear_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .state     (state)
    );

    prbs_checker #(.ERR_CNT_W(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clear_cnt (clear_cnt),
        .locked    (locked2),
        .err_pulse (err_pulse2),
        .err_count (err_count2),
        .state     (state2)
    );

    typedef struct {
        logic        pulse;
        logic        lk;
        logic [15:0] cnt;
    } exp_t;

    exp_t sbq[$];

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] gen;
    int         bitn;
    logic       m_lk;
    int         m_cnt;
    int         m_win;
    int         m_werr;
    int         m_err;
    int         pulses2;
    int         lock_bit;
    logic [7:0] hold_s;

    function automatic logic ref_fb(input logic [7:0] s);
        return ^(s & 8'hB8);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input logic [7:0] seed);
        sbq.delete();
        gen    = seed;
        bitn   = 0;
        m_lk   = 1'b0;
        m_cnt  = 0;
        m_win  = 0;
        m_werr = 0;
        m_err  = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        clear_cnt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset(8'h01);
    endtask

    // Drive one cycle from the generator model, push expectations, compare.
    task automatic send(input logic v, input logic inv, input logic clr);
        logic b;
        logic e;
        exp_t x;
        e = 1'b0;
        b = ref_fb(gen) ^ inv;
        in_valid  = v;
        in_bit    = v ? b : 1'($urandom);
        clear_cnt = clr;
        if (v) begin
            bitn++;
            if (!m_lk) begin
                m_cnt++;
                if (m_cnt == 24) begin
                    m_lk   = 1'b1;
                    m_win  = 0;
                    m_werr = 0;
                end
            end else begin
                e = inv;
                if (e) m_werr++;
                if (m_werr == 4) begin
                    m_lk   = 1'b0;
                    m_cnt  = 0;
                    m_win  = 0;
                    m_werr = 0;
                end else if (m_win == 63) begin
                    m_win  = 0;
                    m_werr = 0;
                end else begin
                    m_win++;
                end
            end
            gen = {gen[6:0], ref_fb(gen)};
        end
        if (clr) m_err = e ? 1 : 0;
        else if (e && m_err < 65535) m_err++;
        x.pulse = e;
        x.lk    = m_lk;
        x.cnt   = 16'(m_err);
        sbq.push_back(x);
        @(negedge clk);
        if (err_pulse2) pulses2++;
        x = sbq.pop_front();
        check("err_pulse", err_pulse, x.pulse);
        check("locked", locked, x.lk);
        check("err_count", err_count, x.cnt);
    endtask

    function automatic logic is_err_bit(input int n);
        int eb[6] = '{30, 60, 88, 89, 120, 152};
        for (int k = 0; k < 6; k++) begin
            if (eb[k] == n) return 1'b1;
        end
        return 1'b0;
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        clear_cnt = 1'b0;
        pulses2   = 0;
        model_reset(8'h01);
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_locked", locked, 0);
        check("rst_pulse", err_pulse, 0);
        check("rst_count", err_count, 0);
        check("rst_state", state, 0);
        rst = 1'b1;

        // All-zero line never locks.
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b0;
            @(negedge clk);
            check("zero_nolock", locked, 0);
        end
        check("zero_state", state, 0);

        // Clean lock from seed 01.
        do_reset();
        lock_bit = 0;
        for (int i = 0; i < 200; i++) begin
            send(1'b1, 1'b0, 1'b0);
            if (locked === 1'b1 && lock_bit == 0) lock_bit = bitn;
        end
        check("clean_lock_bit", lock_bit, 24);
        check("clean_count", err_count, 0);

        // Stalled stream: state holds on idle cycles.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            send(1'b1, 1'b0, 1'b0);
            hold_s = state;
            send(1'b0, 1'b0, 1'b0);
            check("stall_hold", state, hold_s);
        end
        check("stall_locked", locked, 1);

        // Single error, then clear together with an error.
        while (bitn < 39) send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        check("single_pulse", err_pulse, 1);
        check("single_count", err_count, 1);
        send(1'b1, 1'b0, 1'b0);
        check("single_pulse_end", err_pulse, 0);
        check("single_locked", locked, 1);
        while (bitn < 49) send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b1);
        check("clear_err_count", err_count, 1);

        // Four errors in one block drop lock; relock 24 bits later.
        do_reset();
        while (bitn < 29) send(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send(1'b1, 1'b1, 1'b0);
        check("loss_locked", locked, 0);
        check("loss_count", err_count, 4);
        for (int i = 0; i < 23; i++) send(1'b1, 1'b0, 1'b0);
        check("relock_early", locked, 0);
        send(1'b1, 1'b0, 1'b0);
        check("relock", locked, 1);

        // Three errors per block across the window boundary.
        do_reset();
        pulses2 = 0;
        while (bitn < 160) begin
            send(1'b1, is_err_bit(bitn + 1), 1'b0);
            if (bitn == 120) begin
                check("sat_pulses", pulses2, 5);
                check("sat_count", err_count2, 3);
            end
        end
        check("spread_locked", locked, 1);
        check("spread_count", err_count, 6);
        check("spread_locked2", locked2, 1);

        // Asynchronous reset mid-lock.
        #2 rst = 1'b0;
        #1;
        check("async_locked", locked, 0);
        check("async_count", err_count, 0);
        check("async_count2", err_count2, 0);
        @(negedge clk);
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
